rs_multi_cdb: RTL and testbench

Parametrised reservation station for the EXE stage. It sits between the dispatcher and the ALU.
- Holds up to `RS_DEPTH` pending instructions and captures operands from `N_CDB` result broadcast channels.
- Issues ready instructions over a valid/ready handshake and supports a full pipeline flush.
- Successor of the fixed 16-entry, two-source RS. Operand readiness is an explicit flag, not tag==0.

---
 rtl/rs_pkg.sv | 41 ++++
 rtl/rs_pick.sv | 20 ++
 rtl/rs_multi_cdb.sv | 216 +++++++++++++++++++++
 tb/tb_rs_multi_cdb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared widths, entry record and CDB field helpers for the reservation station
package rs_pkg;
    localparam int OP_W      = 6;
    localparam int TAG_W_MAX = 8;
    localparam int CDB_MAX   = 8;
    localparam logic [OP_W-1:0] OP_NOP = '0;

    // Tag fields are sized for the widest supported ROB; users keep the low ROB_W bits.
    typedef struct packed {
        logic                 busy;
        logic [OP_W-1:0]      op;
        logic [TAG_W_MAX-1:0] q1;
        logic                 r1;
        logic [31:0]          v1;
        logic [TAG_W_MAX-1:0] q2;
        logic                 r2;
        logic [31:0]          v2;
        logic [31:0]          pc;
        logic [31:0]          imm;
        logic [TAG_W_MAX-1:0] rob;
    } rs_entry_t;

    function automatic logic [TAG_W_MAX-1:0] cdb_tag(
        input logic [CDB_MAX*TAG_W_MAX-1:0] flat,
        input int unsigned                  c,
        input int unsigned                  w
    );
        logic [CDB_MAX*TAG_W_MAX-1:0] s;
        s = flat >> (c * w);
        return s[TAG_W_MAX-1:0];
    endfunction

    function automatic logic [31:0] cdb_data(
        input logic [CDB_MAX*32-1:0] flat,
        input int unsigned           c
    );
        logic [CDB_MAX*32-1:0] s;
        s = flat >> (c * 32);
        return s[31:0];
    endfunction
endpackage

// File: rtl/rs_pick.sv
// rtl/rs_pick.sv - lowest-index priority encoder
module rs_pick #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] index_o
);
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                index_o = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/rs_multi_cdb.sv
// rtl/rs_multi_cdb.sv - reservation station with multi-channel CDB capture and registered issue
module rs_multi_cdb #(
    parameter int RS_DEPTH = 16,
    parameter int ROB_W    = 4,
    parameter int N_CDB    = 2,
    parameter int OP_W     = 6
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          disp_valid_in,
    input  logic [OP_W-1:0]               disp_op_in,
    input  logic [ROB_W-1:0]              disp_q1_in,
    input  logic [ROB_W-1:0]              disp_q2_in,
    input  logic                          disp_r1_in,
    input  logic                          disp_r2_in,
    input  logic [31:0]                   disp_v1_in,
    input  logic [31:0]                   disp_v2_in,
    input  logic [31:0]                   disp_pc_in,
    input  logic [31:0]                   disp_imm_in,
    input  logic [ROB_W-1:0]              disp_rob_in,
    input  logic [N_CDB-1:0]              cdb_valid_in,
    input  logic [N_CDB*ROB_W-1:0]        cdb_rob_in,
    input  logic [N_CDB*32-1:0]           cdb_data_in,
    input  logic                          flush_in,
    output logic                          issue_valid_out,
    input  logic                          issue_ready_in,
    output logic [OP_W-1:0]               issue_op_out,
    output logic [31:0]                   issue_v1_out,
    output logic [31:0]                   issue_v2_out,
    output logic [31:0]                   issue_pc_out,
    output logic [31:0]                   issue_imm_out,
    output logic [ROB_W-1:0]              issue_rob_out,
    output logic                          full_out,
    output logic [$clog2(RS_DEPTH+1)-1:0] count_out
);
    import rs_pkg::*;

    localparam int CNT_W   = $clog2(RS_DEPTH + 1);
    localparam int IDX_W   = $clog2(RS_DEPTH);
    localparam int EOP_W   = rs_pkg::OP_W;
    localparam int EXT_T_W = CDB_MAX * TAG_W_MAX;
    localparam int EXT_D_W = CDB_MAX * 32;

    rs_entry_t ent_q [RS_DEPTH];
    rs_entry_t ent_d [RS_DEPTH];
    rs_entry_t disp_ent;

    logic [EXT_T_W-1:0]  cdb_rob_ext;
    logic [EXT_D_W-1:0]  cdb_data_ext;
    logic [RS_DEPTH-1:0] busy_vec;
    logic [RS_DEPTH-1:0] ready_vec;
    logic                free_found, sel_found;
    logic [IDX_W-1:0]    free_idx, sel_idx;
    logic                accept, issue_load;

    logic                issue_valid_q;
    logic [OP_W-1:0]     issue_op_q;
    logic [31:0]         issue_v1_q, issue_v2_q, issue_pc_q, issue_imm_q;
    logic [ROB_W-1:0]    issue_rob_q;

    assign cdb_rob_ext  = EXT_T_W'(cdb_rob_in);
    assign cdb_data_ext = EXT_D_W'(cdb_data_in);

    // Returns {hit, data}; scanning high to low lets the lowest matching channel win.
    function automatic logic [32:0] cdb_lookup(input logic [ROB_W-1:0] tag);
        logic [32:0]          res;
        logic [TAG_W_MAX-1:0] t;
        res = '0;
        for (int c = N_CDB - 1; c >= 0; c--) begin
            t = cdb_tag(cdb_rob_ext, c, ROB_W);
            if (cdb_valid_in[c] && (t[ROB_W-1:0] == tag)) begin
                res = {1'b1, cdb_data(cdb_data_ext, c)};
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && ent_q[i].r1 && ent_q[i].r2;
        end
    end

    rs_pick #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_free_pick (
        .req_i   (~busy_vec),
        .found_o (free_found),
        .index_o (free_idx)
    );

    rs_pick #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_sel_pick (
        .req_i   (ready_vec),
        .found_o (sel_found),
        .index_o (sel_idx)
    );

    assign full_out   = &busy_vec;
    assign accept     = disp_valid_in && free_found && rdy_in && !flush_in;
    assign issue_load = rdy_in && !flush_in && (!issue_valid_q || issue_ready_in);

    always_comb begin
        count_out = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            count_out = count_out + CNT_W'(busy_vec[i]);
        end
    end

    always_comb begin
        logic [32:0] byp;
        byp           = '0;
        disp_ent      = '0;
        disp_ent.busy = 1'b1;
        disp_ent.op   = EOP_W'(disp_op_in);
        disp_ent.q1   = TAG_W_MAX'(disp_q1_in);
        disp_ent.r1   = disp_r1_in;
        disp_ent.v1   = disp_v1_in;
        disp_ent.q2   = TAG_W_MAX'(disp_q2_in);
        disp_ent.r2   = disp_r2_in;
        disp_ent.v2   = disp_v2_in;
        disp_ent.pc   = disp_pc_in;
        disp_ent.imm  = disp_imm_in;
        disp_ent.rob  = TAG_W_MAX'(disp_rob_in);
        if (!disp_r1_in) begin
            byp = cdb_lookup(disp_q1_in);
            if (byp[32]) begin
                disp_ent.r1 = 1'b1;
                disp_ent.v1 = byp[31:0];
            end
        end
        if (!disp_r2_in) begin
            byp = cdb_lookup(disp_q2_in);
            if (byp[32]) begin
                disp_ent.r2 = 1'b1;
                disp_ent.v2 = byp[31:0];
            end
        end
    end

    always_comb begin
        logic [32:0] wk;
        wk    = '0;
        ent_d = ent_q;
        if (flush_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_d[i].busy = 1'b0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (ent_q[i].busy && !ent_q[i].r1) begin
                    wk = cdb_lookup(ent_q[i].q1[ROB_W-1:0]);
                    if (wk[32]) begin
                        ent_d[i].r1 = 1'b1;
                        ent_d[i].v1 = wk[31:0];
                    end
                end
                if (ent_q[i].busy && !ent_q[i].r2) begin
                    wk = cdb_lookup(ent_q[i].q2[ROB_W-1:0]);
                    if (wk[32]) begin
                        ent_d[i].r2 = 1'b1;
                        ent_d[i].v2 = wk[31:0];
                    end
                end
            end
            if (issue_load && sel_found) begin
                ent_d[sel_idx].busy = 1'b0;
            end
            // free_idx only ever names a non-busy slot, so it cannot collide with sel_idx.
            if (accept) begin
                ent_d[free_idx] = disp_ent;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            ent_q <= ent_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            issue_valid_q <= 1'b0;
            issue_op_q    <= OP_W'(OP_NOP);
            issue_v1_q    <= '0;
            issue_v2_q    <= '0;
            issue_pc_q    <= '0;
            issue_imm_q   <= '0;
            issue_rob_q   <= '0;
        end else if (flush_in) begin
            issue_valid_q <= 1'b0;
        end else if (issue_load) begin
            issue_valid_q <= sel_found;
            if (sel_found) begin
                issue_op_q  <= OP_W'(ent_q[sel_idx].op);
                issue_v1_q  <= ent_q[sel_idx].v1;
                issue_v2_q  <= ent_q[sel_idx].v2;
                issue_pc_q  <= ent_q[sel_idx].pc;
                issue_imm_q <= ent_q[sel_idx].imm;
                issue_rob_q <= ROB_W'(ent_q[sel_idx].rob);
            end
        end
    end

    assign issue_valid_out = issue_valid_q;
    assign issue_op_out    = issue_op_q;
    assign issue_v1_out    = issue_v1_q;
    assign issue_v2_out    = issue_v2_q;
    assign issue_pc_out    = issue_pc_q;
    assign issue_imm_out   = issue_imm_q;
    assign issue_rob_out   = issue_rob_q;
endmodule

// File: tb/tb_rs_multi_cdb.sv
// tb/tb_rs_multi_cdb.sv - directed self-checking bench for rs_multi_cdb
module tb_rs_multi_cdb;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        disp_valid_in, disp_r1_in, disp_r2_in;
    logic [5:0]  disp_op_in;
    logic [3:0]  disp_q1_in, disp_q2_in, disp_rob_in;
    logic [31:0] disp_v1_in, disp_v2_in, disp_pc_in, disp_imm_in;
    logic [1:0]  cdb_valid_in;
    logic [7:0]  cdb_rob_in;
    logic [63:0] cdb_data_in;
    logic        issue_valid_out, issue_ready_in, full_out;
    logic [5:0]  issue_op_out;
    logic [31:0] issue_v1_out, issue_v2_out, issue_pc_out, issue_imm_out;
    logic [3:0]  issue_rob_out;
    logic [4:0]  count_out;

    int n_assert = 0;
    int n_fail   = 0;

    rs_multi_cdb #(.RS_DEPTH(16), .ROB_W(4), .N_CDB(2), .OP_W(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .disp_valid_in(disp_valid_in), .disp_op_in(disp_op_in),
        .disp_q1_in(disp_q1_in), .disp_q2_in(disp_q2_in),
        .disp_r1_in(disp_r1_in), .disp_r2_in(disp_r2_in),
        .disp_v1_in(disp_v1_in), .disp_v2_in(disp_v2_in),
        .disp_pc_in(disp_pc_in), .disp_imm_in(disp_imm_in), .disp_rob_in(disp_rob_in),
        .cdb_valid_in(cdb_valid_in), .cdb_rob_in(cdb_rob_in), .cdb_data_in(cdb_data_in),
        .flush_in(flush_in),
        .issue_valid_out(issue_valid_out), .issue_ready_in(issue_ready_in),
        .issue_op_out(issue_op_out), .issue_v1_out(issue_v1_out), .issue_v2_out(issue_v2_out),
        .issue_pc_out(issue_pc_out), .issue_imm_out(issue_imm_out), .issue_rob_out(issue_rob_out),
        .full_out(full_out), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic disp(input logic v, input logic [5:0] op, input logic [3:0] q1, input logic r1,
                        input logic [31:0] v1, input logic [3:0] q2, input logic r2,
                        input logic [31:0] v2, input logic [3:0] rob);
        disp_valid_in = v;
        disp_op_in    = op;
        disp_q1_in    = q1;
        disp_r1_in    = r1;
        disp_v1_in    = v1;
        disp_q2_in    = q2;
        disp_r2_in    = r2;
        disp_v2_in    = v2;
        disp_rob_in   = rob;
        disp_pc_in    = 32'h1000 + 32'(op);
        disp_imm_in   = 32'(op);
    endtask

    task automatic cdb(input logic [1:0] v, input logic [3:0] t1, input logic [31:0] d1,
                       input logic [3:0] t0, input logic [31:0] d0);
        cdb_valid_in = v;
        cdb_rob_in   = {t1, t0};
        cdb_data_in  = {d1, d0};
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; issue_ready_in = 1'b0;
        disp(1'b0, 6'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        step(); step();
        rst_in = 1'b0;
        step();
        chk("reset_valid", 32'(issue_valid_out), 32'd0);
        chk("reset_count", 32'(count_out), 32'd0);
        chk("reset_full",  32'(full_out), 32'd0);
        chk("reset_op",    32'(issue_op_out), 32'd0);
        chk("reset_v1",    issue_v1_out, 32'd0);

        // Fill: the first entry moves into the issue register, so 17 dispatches fill 16 slots.
        disp(1'b1, 6'd1, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd100, 4'd0);
        step();
        chk("fill1_count", 32'(count_out), 32'd1);
        chk("fill1_valid", 32'(issue_valid_out), 32'd0);
        disp(1'b1, 6'd2, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd101, 4'd1);
        step();
        chk("fill2_valid", 32'(issue_valid_out), 32'd1);
        chk("fill2_op",    32'(issue_op_out), 32'd1);
        chk("fill2_count", 32'(count_out), 32'd1);
        for (int i = 2; i < 17; i++) begin
            disp(1'b1, 6'(i + 1), 4'd0, 1'b1, 32'(i), 4'd0, 1'b1, 32'(100 + i), 4'(i));
            step();
        end
        chk("full_flag",  32'(full_out), 32'd1);
        chk("full_count", 32'(count_out), 32'd16);
        disp(1'b1, 6'd18, 4'd0, 1'b1, 32'd17, 4'd0, 1'b1, 32'd117, 4'd1);
        step(); step();
        chk("reject_count", 32'(count_out), 32'd16);
        chk("hold_op",      32'(issue_op_out), 32'd1);
        chk("hold_v2",      issue_v2_out, 32'd100);
        chk("hold_valid",   32'(issue_valid_out), 32'd1);

        disp(1'b0, 6'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        chk("clr_count", 32'(count_out), 32'd0);
        chk("clr_full",  32'(full_out), 32'd0);
        chk("clr_valid", 32'(issue_valid_out), 32'd0);

        // Dispatch-time bypass from channel 1
        issue_ready_in = 1'b1;
        disp(1'b1, 6'd20, 4'd3, 1'b0, 32'd0, 4'd0, 1'b1, 32'h55, 4'd7);
        cdb(2'b10, 4'd3, 32'hDEAD, 4'd0, 32'd0);
        step();
        disp(1'b0, 6'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        chk("byp_count0", 32'(count_out), 32'd1);
        chk("byp_valid0", 32'(issue_valid_out), 32'd0);
        step();
        chk("byp_valid", 32'(issue_valid_out), 32'd1);
        chk("byp_op",    32'(issue_op_out), 32'd20);
        chk("byp_v1",    issue_v1_out, 32'hDEAD);
        chk("byp_v2",    issue_v2_out, 32'h55);
        chk("byp_rob",   32'(issue_rob_out), 32'd7);
        chk("byp_pc",    issue_pc_out, 32'h1014);
        chk("byp_count", 32'(count_out), 32'd0);
        step();
        chk("byp_drain", 32'(issue_valid_out), 32'd0);

        // Both operands woken by different channels in one cycle
        disp(1'b1, 6'd21, 4'd5, 1'b0, 32'd0, 4'd6, 1'b0, 32'd0, 4'd9);
        step();
        disp(1'b0, 6'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        step();
        chk("wait_count", 32'(count_out), 32'd1);
        chk("wait_valid", 32'(issue_valid_out), 32'd0);
        cdb(2'b11, 4'd6, 32'h22, 4'd5, 32'h11);
        step();
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        chk("wake_valid0", 32'(issue_valid_out), 32'd0);
        step();
        chk("wake_valid", 32'(issue_valid_out), 32'd1);
        chk("wake_op",    32'(issue_op_out), 32'd21);
        chk("wake_v1",    issue_v1_out, 32'h11);
        chk("wake_v2",    issue_v2_out, 32'h22);
        step();

        // Same tag on both channels: channel 0 wins
        disp(1'b1, 6'd22, 4'd2, 1'b0, 32'd0, 4'd0, 1'b1, 32'h77, 4'd3);
        step();
        disp(1'b0, 6'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        cdb(2'b11, 4'd2, 32'hB, 4'd2, 32'hA);
        step();
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        step();
        chk("coll_valid", 32'(issue_valid_out), 32'd1);
        chk("coll_v1",    issue_v1_out, 32'hA);
        step();

        // Flush with eight busy entries and a live issue register
        issue_ready_in = 1'b0;
        for (int i = 0; i < 9; i++) begin
            disp(1'b1, 6'(30 + i), 4'd0, 1'b1, 32'(i), 4'd0, 1'b1, 32'd0, 4'(i));
            step();
        end
        chk("pre_flush_count", 32'(count_out), 32'd8);
        chk("pre_flush_valid", 32'(issue_valid_out), 32'd1);
        chk("pre_flush_op",    32'(issue_op_out), 32'd30);
        disp(1'b1, 6'd50, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        disp(1'b0, 6'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        chk("flush_count", 32'(count_out), 32'd0);
        chk("flush_valid", 32'(issue_valid_out), 32'd0);
        step();
        chk("flush_drop_count", 32'(count_out), 32'd0);
        chk("flush_drop_valid", 32'(issue_valid_out), 32'd0);

        // Freeze with rdy_in low
        disp(1'b1, 6'd60, 4'd0, 1'b1, 32'h60, 4'd0, 1'b1, 32'd0, 4'd1);
        step();
        disp(1'b1, 6'd61, 4'd4, 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, 4'd2);
        step();
        chk("frz_setup_count", 32'(count_out), 32'd1);
        chk("frz_setup_op",    32'(issue_op_out), 32'd60);
        rdy_in = 1'b0;
        issue_ready_in = 1'b1;
        disp(1'b1, 6'd62, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd3);
        cdb(2'b01, 4'd0, 32'd0, 4'd4, 32'h99);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_count", 32'(count_out), 32'd1);
            chk("frz_op",    32'(issue_op_out), 32'd60);
            chk("frz_valid", 32'(issue_valid_out), 32'd1);
        end
        rdy_in = 1'b1;
        disp(1'b0, 6'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        step();
        chk("frz_nowake_valid", 32'(issue_valid_out), 32'd0);
        chk("frz_nowake_count", 32'(count_out), 32'd1);
        cdb(2'b01, 4'd0, 32'd0, 4'd4, 32'h99);
        step();
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        disp(1'b1, 6'd63, 4'd9, 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, 4'd4);
        step();
        disp(1'b0, 6'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        issue_ready_in = 1'b0;
        chk("late_valid", 32'(issue_valid_out), 32'd1);
        chk("late_op",    32'(issue_op_out), 32'd61);
        chk("late_v1",    issue_v1_out, 32'h99);
        chk("late_count", 32'(count_out), 32'd1);

        // Asynchronous reset between clock edges
        #1;
        rst_in = 1'b1;
        #1;
        chk("arst_valid", 32'(issue_valid_out), 32'd0);
        chk("arst_op",    32'(issue_op_out), 32'd0);
        chk("arst_v1",    issue_v1_out, 32'd0);
        chk("arst_count", 32'(count_out), 32'd0);
        chk("arst_full",  32'(full_out), 32'd0);
        step();
        rst_in = 1'b0;
        step();
        chk("post_rst_valid", 32'(issue_valid_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
